axi_burst_mem_slave: RTL and testbench

AXI4 full-protocol slave memory inside chip. It is the downstream target of the AXI master VIP stimulus and the endpoint whose traffic the testbench monitors and scoreboards. It accepts INCR, FIXED and WRAP bursts, applies byte strobes to an internal word memory and returns per-beat read data and responses. Write and read paths are independent, each with one outstanding transaction.

---
 rtl/axi_slv_pkg.sv | 36 +++
 rtl/axi_burst_addr_gen.sv | 53 +++++
 rtl/axi_burst_mem_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI burst memory slave: burst encodings, response codes,
// write/read FSM state enums and the response-merge helper.
// Pure declarations; no logic, no latency, no flow control.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

    // Response codes are ordered so that the numerically larger code is the
    // more severe one (OKAY < SLVERR < DECERR).
    function automatic logic [1:0] max_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: next beat address, memory word index, range and protocol checks.
// Purely combinational, zero latency.
// No flow control; the owning FSM decides when to consume next_addr.
// Ports: addr/len/size/burst in -> next_addr, word_idx, out_of_range, proto_err out.
module axi_burst_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 1024
) (
    input  logic [ADDR_W-1:0]            addr,
    input  logic [7:0]                   len,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [ADDR_W-1:0]            next_addr,
    output logic [$clog2(MEM_WORDS)-1:0] word_idx,
    output logic                         out_of_range,
    output logic                         proto_err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int ALSB   = $clog2(NBYTES);
    localparam int MIDX_W = $clog2(MEM_WORDS);
    localparam int WIDX_W = ADDR_W - ALSB;

    logic [ADDR_W-1:0] beat_bytes;
    logic [ADDR_W-1:0] wrap_mask;
    logic [WIDX_W-1:0] full_idx;
    logic              wrap_len_ok;

    always_comb begin
        beat_bytes = ADDR_W'(1) << size;
        // Wrap window is (len+1) beats; only meaningful for len in {1,3,7,15},
        // where it is a power of two and the mask below is contiguous.
        wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst_t'(burst))
            INCR:    next_addr = (addr & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;
            WRAP:    next_addr = (addr & ~wrap_mask) | ((addr + beat_bytes) & wrap_mask);
            default: next_addr = addr;
        endcase
    end

    assign full_idx     = addr[ADDR_W-1:ALSB];
    assign word_idx     = full_idx[MIDX_W-1:0];
    assign out_of_range = (32'(full_idx) >= 32'(MEM_WORDS));

    assign wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    assign proto_err    = (32'(size) > 32'(ALSB))
                       || (burst == 2'b11)
                       || ((burst == 2'b10) && !wrap_len_ok);

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 slave over an inferred word memory; INCR/FIXED/WRAP bursts, byte strobes, one txn per path.
// Write: one beat per cycle; read: AR->first rvalid 2 cycles, then 1 beat per 2 cycles.
// Each channel stalls on its own ready/valid; R payload is held stable while rready is low.
// Ports: aclk/aresetn; AW, W, B channels (write path); AR, R channels (read path).
module axi_burst_mem_slave
    import axi_slv_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int MIDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // ---------------- write path ----------------
    wr_state_t         w_q, w_d;
    logic [ID_W-1:0]   wid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wlen_q, wbeat_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q, wresp_q;
    logic              awready_q, wready_q, bvalid_q;

    logic [ADDR_W-1:0] w_next;
    logic [MIDX_W-1:0] w_idx;
    logic              w_oor, w_perr;
    logic              aw_hs, w_hs, b_hs, w_last_beat, wlast_err, mem_we;
    logic [1:0]        w_beat_resp;

    axi_burst_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_wgen (
        .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q),
        .next_addr(w_next), .word_idx(w_idx), .out_of_range(w_oor), .proto_err(w_perr)
    );

    assign aw_hs       = awready_q & s_axi_awvalid;
    assign w_hs        = wready_q & s_axi_wvalid;
    assign b_hs        = bvalid_q & s_axi_bready;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign wlast_err   = (s_axi_wlast != w_last_beat);
    assign w_beat_resp = max_resp((w_perr | wlast_err) ? SLVERR : OKAY, w_oor ? DECERR : OKAY);
    // A misplaced wlast is flagged but the data is still stored; header errors
    // and out-of-range beats are dropped.
    assign mem_we      = w_hs & ~w_perr & ~w_oor;

    always_comb begin
        w_d = w_q;
        case (w_q)
            W_IDLE:  if (aw_hs) w_d = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_d = W_RESP;
            W_RESP:  if (b_hs) w_d = W_IDLE;
            default: w_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_q       <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wresp_q   <= OKAY;
        end else begin
            w_q       <= w_d;
            // Handshake flags are registered copies of the next state so they
            // stay low through reset and rise one edge after release.
            awready_q <= (w_d == W_IDLE);
            wready_q  <= (w_d == W_DATA);
            bvalid_q  <= (w_d == W_RESP);
            if (aw_hs) begin
                wid_q    <= s_axi_awid;
                waddr_q  <= s_axi_awaddr;
                wlen_q   <= s_axi_awlen;
                wsize_q  <= s_axi_awsize;
                wburst_q <= s_axi_awburst;
                wbeat_q  <= '0;
                wresp_q  <= OKAY;
            end
            if (w_hs) begin
                waddr_q <= w_next;
                wbeat_q <= wbeat_q + 8'd1;
                wresp_q <= max_resp(wresp_q, w_beat_resp);
            end
        end
    end

    // Memory is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = wresp_q;

    // ---------------- read path ----------------
    rd_state_t         r_q, r_d;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [7:0]        rlen_q, rbeat_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              arready_q, rvalid_q, rlast_q;

    logic [ADDR_W-1:0] r_next;
    logic [MIDX_W-1:0] r_idx;
    logic              r_oor, r_perr;
    logic              ar_hs, r_hs;

    axi_burst_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_rgen (
        .addr(raddr_q), .len(rlen_q), .size(rsize_q), .burst(rburst_q),
        .next_addr(r_next), .word_idx(r_idx), .out_of_range(r_oor), .proto_err(r_perr)
    );

    assign ar_hs = arready_q & s_axi_arvalid;
    assign r_hs  = rvalid_q & s_axi_rready;

    always_comb begin
        r_d = r_q;
        case (r_q)
            R_IDLE:  if (ar_hs) r_d = R_FETCH;
            R_FETCH: r_d = R_DATA;
            R_DATA:  if (r_hs) r_d = rlast_q ? R_IDLE : R_FETCH;
            default: r_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_q       <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_q       <= r_d;
            arready_q <= (r_d == R_IDLE);
            rvalid_q  <= (r_d == R_DATA);
            if (ar_hs) begin
                rid_q    <= s_axi_arid;
                raddr_q  <= s_axi_araddr;
                rlen_q   <= s_axi_arlen;
                rsize_q  <= s_axi_arsize;
                rburst_q <= s_axi_arburst;
                rbeat_q  <= '0;
            end
            // Payload is captured once per beat and then frozen until rready,
            // so a same-cycle write to this word is not visible (read-first).
            if (r_q == R_FETCH) begin
                rdata_q <= (r_oor || r_perr) ? '0 : mem[r_idx];
                rresp_q <= max_resp(r_perr ? SLVERR : OKAY, r_oor ? DECERR : OKAY);
                rlast_q <= (rbeat_q == rlen_q);
            end
            if (r_hs) begin
                raddr_q <= r_next;
                rbeat_q <= rbeat_q + 8'd1;
            end
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
module tb_axi_burst_mem_slave;
    import axi_slv_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int IW  = 4;
    localparam int MW  = 1024;
    localparam int LIM = 100;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_burst_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .MEM_WORDS(MW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] wd [16];
    logic [3:0]    ws [16];
    logic          wl [16];
    logic          use_wl = 1'b0;
    logic [DW-1:0] rd_d [16];
    logic [1:0]    rd_r [16];
    logic          rd_l [16];
    logic [IW-1:0] rd_id;
    logic [1:0]    got_bresp;
    logic [IW-1:0] got_bid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("awready_timeout", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input int len, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            wdata = wd[i]; wstrb = ws[i];
            wlast = use_wl ? wl[i] : (i == len);
            wvalid = 1'b1;
            while (wready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
            if (n >= LIM) check("wready_timeout", wready, 1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b();
        int n = 0;
        bready = 1'b1;
        while (bvalid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("bvalid_timeout", bvalid, 1);
        got_bresp = bresp; got_bid = bid;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        do_aw(id, a, len, size, burst);
        do_w(int'(len), int'(len) + 1);
        do_b();
    endtask

    task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int stall, input logic [DW-1:0] stall_exp);
        int n = 0;
        arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (arready !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
        if (n >= LIM) check("arready_timeout", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        check("r_fetch_gap", rvalid, 0);
        @(negedge aclk);
        check("r_first_latency", rvalid, 1);
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (rvalid !== 1'b1 && n < LIM) begin @(negedge aclk); n++; end
            if (n >= LIM) check("rvalid_timeout", rvalid, 1);
            if (i == 0) begin
                for (int s = 0; s < stall; s++) begin
                    check("stall_rvalid", rvalid, 1);
                    check("stall_rdata", rdata, stall_exp);
                    @(negedge aclk);
                end
            end
            rd_d[i] = rdata; rd_r[i] = rresp; rd_l[i] = rlast; rd_id = rid;
            rready = 1'b1;
            @(negedge aclk);
            rready = 1'b0;
            check("r_beat_gap", rvalid, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge aclk);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        aresetn = 1'b1;
        check("awready_before_edge", awready, 0);
        @(negedge aclk);
        check("awready_after_edge", awready, 1);
        check("arready_after_edge", arready, 1);

        // ---- single beat write/read ----
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(4'd3, 16'h0010, 8'd0, 3'd2, INCR);
        check("t1_bresp", got_bresp, 0);
        check("t1_bid", got_bid, 3);
        read_burst(4'd3, 16'h0010, 8'd0, 3'd2, INCR, 0, '0);
        check("t1_rdata", rd_d[0], 32'hDEADBEEF);
        check("t1_rresp", rd_r[0], 0);
        check("t1_rlast", rd_l[0], 1);
        check("t1_rid", rd_id, 3);

        // ---- INCR len=3 with a partial strobe on beat 2 ----
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
        write_burst(4'd1, 16'h0100, 8'd3, 3'd2, INCR);
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        ws[2] = 4'h3;
        write_burst(4'd2, 16'h0100, 8'd3, 3'd2, INCR);
        check("t2_bresp", got_bresp, 0);
        read_burst(4'd2, 16'h0100, 8'd3, 3'd2, INCR, 0, '0);
        check("t2_beat0", rd_d[0], 32'h11111111);
        check("t2_beat1", rd_d[1], 32'h22222222);
        check("t2_beat2", rd_d[2], 32'hFFFF3333);
        check("t2_beat3", rd_d[3], 32'h44444444);
        check("t2_rlast0", rd_l[0], 0);
        check("t2_rlast2", rd_l[2], 0);
        check("t2_rlast3", rd_l[3], 1);

        // ---- WRAP len=3 starting mid-window ----
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        write_burst(4'd4, 16'h0038, 8'd3, 3'd2, WRAP);
        check("t3_bresp", got_bresp, 0);
        read_burst(4'd4, 16'h0030, 8'd3, 3'd2, INCR, 0, '0);
        check("t3_0x30", rd_d[0], 3);
        check("t3_0x34", rd_d[1], 4);
        check("t3_0x38", rd_d[2], 1);
        check("t3_0x3C", rd_d[3], 2);

        // ---- DECERR beyond the end of memory ----
        wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
        write_burst(4'd0, 16'h0000, 8'd0, 3'd2, INCR);
        read_burst(4'd5, 16'(4 * MW), 8'd1, 3'd2, INCR, 0, '0);
        check("t4_rdata0", rd_d[0], 0);
        check("t4_rresp0", rd_r[0], 3);
        check("t4_rdata1", rd_d[1], 0);
        check("t4_rresp1", rd_r[1], 3);
        check("t4_rlast1", rd_l[1], 1);
        wd[0] = 32'hABCD0123;
        write_burst(4'd5, 16'(4 * MW), 8'd0, 3'd2, INCR);
        check("t4_bresp", got_bresp, 3);
        read_burst(4'd5, 16'h0000, 8'd0, 3'd2, INCR, 0, '0);
        check("t4_no_alias", rd_d[0], 32'h0BADF00D);

        // ---- rready backpressure and oversize write ----
        read_burst(4'd6, 16'h0100, 8'd1, 3'd2, INCR, 5, 32'h11111111);
        check("t5_beat1", rd_d[1], 32'h22222222);
        wd[0] = 32'h12345678;
        write_burst(4'd7, 16'h0010, 8'd0, 3'd3, INCR);
        check("t5_size_bresp", got_bresp, 2);
        check("t5_size_bid", got_bid, 7);
        read_burst(4'd7, 16'h0010, 8'd0, 3'd2, INCR, 0, '0);
        check("t5_size_nowrite", rd_d[0], 32'hDEADBEEF);

        // ---- misplaced wlast: SLVERR but data kept ----
        wd[0] = 32'hCAFE0000; wd[1] = 32'hCAFE0001; ws[0] = 4'hF; ws[1] = 4'hF;
        wl[0] = 1'b1; wl[1] = 1'b0; use_wl = 1'b1;
        write_burst(4'd8, 16'h0200, 8'd1, 3'd2, INCR);
        use_wl = 1'b0;
        check("t6_wlast_bresp", got_bresp, 2);
        read_burst(4'd8, 16'h0200, 8'd1, 3'd2, INCR, 0, '0);
        check("t6_wlast_data0", rd_d[0], 32'hCAFE0000);
        check("t6_wlast_data1", rd_d[1], 32'hCAFE0001);

        // ---- WRAP with illegal length ----
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h5A5A5A5A; ws[i] = 4'hF; end
        write_burst(4'd9, 16'h0030, 8'd2, 3'd2, WRAP);
        check("t7_wrap_len_bresp", got_bresp, 2);
        read_burst(4'd9, 16'h0030, 8'd0, 3'd2, INCR, 0, '0);
        check("t7_wrap_len_nowrite", rd_d[0], 3);
        read_burst(4'd9, 16'h0030, 8'd2, 3'd2, WRAP, 0, '0);
        check("t7_rd_wrap_len_rresp", rd_r[2], 2);

        // ---- reset in the middle of a write burst ----
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_aw(4'd10, 16'h0300, 8'd3, 3'd2, INCR);
        do_w(3, 2);
        aresetn = 1'b0;
        #1;
        check("t8_rst_wready", wready, 0);
        check("t8_rst_awready", awready, 0);
        check("t8_rst_bvalid", bvalid, 0);
        check("t8_rst_rvalid", rvalid, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        check("t8_awready_held", awready, 0);
        @(negedge aclk);
        check("t8_awready_up", awready, 1);
        repeat (3) @(negedge aclk);
        check("t8_no_bresp", bvalid, 0);
        read_burst(4'd10, 16'h0300, 8'd1, 3'd2, INCR, 0, '0);
        check("t8_beat0_kept", rd_d[0], 32'hA0);
        check("t8_beat1_kept", rd_d[1], 32'hA1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
